// File: rtl/uart_alu_pkt_rx_pkg.sv
// rtl/uart_alu_pkt_rx_pkg.sv - shared constants and types for the UART ALU packet receiver
package uart_alu_pkt_rx_pkg;

  localparam logic [7:0] OP_ECHO = 8'hEC;
  localparam logic [7:0] OP_ADD  = 8'hAD;
  localparam logic [7:0] OP_MUL  = 8'h8A;
  localparam logic [7:0] OP_DIV  = 8'hD1;

  localparam int HDR_BYTES = 4;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_OPCODE  = 2'd1,
    ERR_LENGTH  = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_code_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR_RSVD,
    ST_HDR_LLSB,
    ST_HDR_LMSB,
    ST_PAYLOAD,
    ST_DROP
  } state_t;

  function automatic logic is_legal_op(input logic [7:0] op);
    return (op == OP_ECHO) || (op == OP_ADD) || (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/uart_alu_byte_fifo.sv
// rtl/uart_alu_byte_fifo.sv - small synchronous FIFO for tagged payload bytes
module uart_alu_byte_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count == (AW+1)'(DEPTH));
  assign empty_o = (count == '0);
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem[rd_ptr];

  // Storage array; contents are don't-care until counted valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= push_data_i;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-2 depth).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_alu_pkt_rx.sv
// rtl/uart_alu_pkt_rx.sv - header parser and payload forwarder for the UART ALU byte stream
module uart_alu_pkt_rx
  import uart_alu_pkt_rx_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        pkt_start_o,
  output logic [7:0]  opcode_o,
  output logic [15:0] len_o,
  output logic [7:0]  data_o,
  output logic        data_last_o,
  output logic        data_valid_o,
  input  logic        data_ready_i,
  output logic        err_o,
  output logic [1:0]  err_code_o,
  output logic        overflow_o
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t      state;
  err_code_t   err_code_q;
  logic [7:0]  op_q;
  logic [7:0]  len_lsb_q;
  logic [15:0] remaining;
  logic [TMO_W-1:0] idle_cnt;

  logic [15:0] hdr_len;
  logic [15:0] pay_len;
  logic        op_legal;
  logic        op_arith;

  logic        fifo_push;
  logic        fifo_pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic [8:0]  fifo_head;

  // Header length decode, only meaningful while the len_msb byte is on the bus.
  always_comb begin
    hdr_len  = {rx_data_i, len_lsb_q};
    pay_len  = hdr_len - 16'(HDR_BYTES);
    op_legal = is_legal_op(op_q);
    op_arith = op_legal && (op_q != OP_ECHO);
  end

  assign fifo_push    = (state == ST_PAYLOAD) && rx_valid_i;
  assign fifo_pop     = data_valid_o && data_ready_i;
  assign data_valid_o = !fifo_empty;
  // Gate the head so an empty FIFO never shows stale storage.
  assign data_o       = fifo_empty ? 8'h00 : fifo_head[7:0];
  assign data_last_o  = !fifo_empty && fifo_head[8];
  assign err_code_o   = err_code_q;

  // Parser FSM with inter-byte timeout; pulses and held header fields are registered here.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      err_code_q  <= ERR_NONE;
      op_q        <= '0;
      len_lsb_q   <= '0;
      remaining   <= '0;
      idle_cnt    <= '0;
      pkt_start_o <= 1'b0;
      opcode_o    <= '0;
      len_o       <= '0;
      err_o       <= 1'b0;
    end else begin
      pkt_start_o <= 1'b0;
      err_o       <= 1'b0;

      if (state == ST_IDLE || rx_valid_i) begin
        idle_cnt <= '0;
      end else if (idle_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
        idle_cnt   <= '0;
        err_o      <= 1'b1;
        err_code_q <= ERR_TIMEOUT;
        state      <= ST_IDLE;
      end else begin
        idle_cnt <= idle_cnt + 1'b1;
      end

      if (rx_valid_i) begin
        case (state)
          ST_IDLE: begin
            op_q  <= rx_data_i;
            state <= ST_HDR_RSVD;
          end
          ST_HDR_RSVD: state <= ST_HDR_LLSB;
          ST_HDR_LLSB: begin
            len_lsb_q <= rx_data_i;
            state     <= ST_HDR_LMSB;
          end
          ST_HDR_LMSB: begin
            remaining <= pay_len;
            if (hdr_len < 16'(HDR_BYTES)) begin
              err_o      <= 1'b1;
              err_code_q <= ERR_LENGTH;
              state      <= ST_IDLE;
            end else if (!op_legal) begin
              err_o      <= 1'b1;
              err_code_q <= ERR_OPCODE;
              state      <= (pay_len != '0) ? ST_DROP : ST_IDLE;
            end else if (op_arith && (pay_len[1:0] != 2'b00 || pay_len < 16'd8)) begin
              err_o      <= 1'b1;
              err_code_q <= ERR_LENGTH;
              state      <= (pay_len != '0) ? ST_DROP : ST_IDLE;
            end else begin
              pkt_start_o <= 1'b1;
              opcode_o    <= op_q;
              len_o       <= hdr_len;
              state       <= (pay_len != '0) ? ST_PAYLOAD : ST_IDLE;
            end
          end
          ST_PAYLOAD, ST_DROP: begin
            remaining <= remaining - 1'b1;
            if (remaining == 16'd1) state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Sticky flag for payload bytes lost to a full FIFO.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) overflow_o <= 1'b0;
    else if (fifo_push && fifo_full && !fifo_pop) overflow_o <= 1'b1;
  end

  uart_alu_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (9)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (fifo_push),
    .push_data_i ({remaining == 16'd1, rx_data_i}),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

endmodule

// File: tb/tb_uart_alu_pkt_rx.sv
// tb/tb_uart_alu_pkt_rx.sv - self-checking bench for uart_alu_pkt_rx
module tb_uart_alu_pkt_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        pkt_start;
  logic [7:0]  opcode;
  logic [15:0] len;
  logic [7:0]  data;
  logic        data_last;
  logic        data_valid;
  logic        data_ready;
  logic        err;
  logic [1:0]  err_code;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  logic [23:0] exp_start [$];
  logic [1:0]  exp_err   [$];
  logic [8:0]  exp_data  [$];

  typedef struct packed {
    logic [95:0] pkt;
    logic [3:0]  n;
    logic        start;
    logic [7:0]  op;
    logic [15:0] len;
    logic [1:0]  err;
    logic [71:0] dat;
    logic [3:0]  nd;
  } vec_t;

  vec_t vecs [10];

  always #5 clk = ~clk;

  uart_alu_pkt_rx #(
    .FIFO_DEPTH     (4),
    .TIMEOUT_CYCLES (50)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .rx_data_i    (rx_data),
    .rx_valid_i   (rx_valid),
    .pkt_start_o  (pkt_start),
    .opcode_o     (opcode),
    .len_o        (len),
    .data_o       (data),
    .data_last_o  (data_last),
    .data_valid_o (data_valid),
    .data_ready_i (data_ready),
    .err_o        (err),
    .err_code_o   (err_code),
    .overflow_o   (overflow)
  );

  function automatic vec_t mk(input logic [95:0] pkt, input int n, input logic start,
                              input logic [7:0] op, input logic [15:0] l, input logic [1:0] e,
                              input logic [71:0] dat, input int nd);
    vec_t v;
    v.pkt = pkt; v.n = 4'(n); v.start = start; v.op = op; v.len = l;
    v.err = e; v.dat = dat; v.nd = 4'(nd);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s actual=%0h expected=none", name, act);
  endtask

  // Scoreboard: compare whatever the DUT presents this cycle against the queued expectations.
  task automatic mon();
    logic [23:0] s;
    if (pkt_start || err) chk("start_err_exclusive", {31'b0, pkt_start & err}, 32'd0);
    if (pkt_start) begin
      if (exp_start.size() == 0) unexpected("start_unexpected", {8'h0, opcode, len});
      else begin
        s = exp_start.pop_front();
        chk("opcode", {24'h0, opcode}, {24'h0, s[23:16]});
        chk("len", {16'h0, len}, {16'h0, s[15:0]});
      end
    end
    if (err) begin
      if (exp_err.size() == 0) unexpected("err_unexpected", {30'h0, err_code});
      else chk("err_code", {30'h0, err_code}, {30'h0, exp_err.pop_front()});
    end
    if (data_valid && data_ready) begin
      if (exp_data.size() == 0) unexpected("data_unexpected", {23'h0, data_last, data});
      else chk("data", {23'h0, data_last, data}, {23'h0, exp_data.pop_front()});
    end
  endtask

  task automatic cyc();
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    cyc();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    cyc();
  endtask

  task automatic chk_drained(input string tag);
    chk({tag, "_start_left"}, exp_start.size(), 32'd0);
    chk({tag, "_err_left"}, exp_err.size(), 32'd0);
    chk({tag, "_data_left"}, exp_data.size(), 32'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_pkt_start"}, {31'b0, pkt_start}, 32'd0);
    chk({tag, "_opcode"}, {24'b0, opcode}, 32'd0);
    chk({tag, "_len"}, {16'b0, len}, 32'd0);
    chk({tag, "_data"}, {24'b0, data}, 32'd0);
    chk({tag, "_last"}, {31'b0, data_last}, 32'd0);
    chk({tag, "_valid"}, {31'b0, data_valid}, 32'd0);
    chk({tag, "_err"}, {31'b0, err}, 32'd0);
    chk({tag, "_err_code"}, {30'b0, err_code}, 32'd0);
    chk({tag, "_overflow"}, {31'b0, overflow}, 32'd0);
  endtask

  task automatic apply_vec(input vec_t v);
    data_ready = 1'b1;
    if (v.start) exp_start.push_back({v.op, v.len});
    if (v.err != 2'd0) exp_err.push_back(v.err);
    for (int i = 0; i < int'(v.nd); i++) exp_data.push_back(v.dat[i*9 +: 9]);
    for (int i = 0; i < int'(v.n); i++) send_byte(v.pkt[i*8 +: 8]);
    repeat (4) cyc();
    chk_drained("vec");
  endtask

  initial begin
    int j;

    vecs[0] = mk(96'({8'h42, 8'h69, 8'h00, 8'h06, 8'h00, 8'hEC}), 6, 1, 8'hEC, 16'd6, 2'd0,
                 72'({9'h142, 9'h069}), 2);
    vecs[1] = mk(96'({8'hBB, 8'hAA, 8'h00, 8'h06, 8'h00, 8'h55}), 6, 0, 8'h00, 16'd0, 2'd1, 72'h0, 0);
    vecs[2] = mk(96'({8'h00, 8'h04, 8'h00, 8'hEC}), 4, 1, 8'hEC, 16'd4, 2'd0, 72'h0, 0);
    vecs[3] = mk(96'({8'h03, 8'h02, 8'h01, 8'h00, 8'h07, 8'h00, 8'hAD}), 7, 0, 8'h00, 16'd0, 2'd2,
                 72'h0, 0);
    vecs[4] = mk(96'({8'h77, 8'h00, 8'h05, 8'h00, 8'hEC}), 5, 1, 8'hEC, 16'd5, 2'd0, 72'({9'h177}), 1);
    vecs[5] = mk(96'({8'h00, 8'h03, 8'h00, 8'h12}), 4, 0, 8'h00, 16'd0, 2'd2, 72'h0, 0);
    vecs[6] = mk({8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00, 8'h0C, 8'h00, 8'hAD},
                 12, 1, 8'hAD, 16'd12, 2'd0,
                 {9'h108, 9'h007, 9'h006, 9'h005, 9'h004, 9'h003, 9'h002, 9'h001}, 8);
    vecs[7] = mk(96'({8'h04, 8'h03, 8'h02, 8'h01, 8'h00, 8'h08, 8'h00, 8'h8A}), 8, 0, 8'h00, 16'd0,
                 2'd2, 72'h0, 0);
    vecs[8] = mk(96'({8'h00, 8'h04, 8'h00, 8'h33}), 4, 0, 8'h00, 16'd0, 2'd1, 72'h0, 0);
    vecs[9] = mk({8'hF7, 8'hF6, 8'hF5, 8'hF4, 8'hF3, 8'hF2, 8'hF1, 8'hF0, 8'h00, 8'h0C, 8'h00, 8'hD1},
                 12, 1, 8'hD1, 16'd12, 2'd0,
                 {9'h1F7, 9'h0F6, 9'h0F5, 9'h0F4, 9'h0F3, 9'h0F2, 9'h0F1, 9'h0F0}, 8);

    rst = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    data_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;
    cyc();

    for (int i = 0; i < 10; i++) apply_vec(vecs[i]);

    // Timeout mid-payload: error exactly 50 cycles after the last strobe, partial byte kept.
    data_ready = 1'b0;
    exp_start.push_back({8'hEC, 16'd8});
    exp_err.push_back(2'd3);
    send_byte(8'hEC); send_byte(8'h00); send_byte(8'h08); send_byte(8'h00);
    rx_valid = 1'b1;
    rx_data = 8'h11;
    cyc();
    rx_valid = 1'b0;
    rx_data = 8'h00;
    j = 0;
    while (!err && j < 60) begin
      cyc();
      j++;
    end
    chk("timeout_latency", j, 32'd50);
    chk("timeout_head_valid", {31'b0, data_valid}, 32'd1);
    chk("timeout_head_data", {24'b0, data}, 32'h11);
    chk("timeout_head_last", {31'b0, data_last}, 32'd0);
    cyc();
    exp_data.push_back(9'h011);
    data_ready = 1'b1;
    repeat (3) cyc();
    chk_drained("timeout");
    apply_vec(vecs[0]);

    // Overflow: consumer stalled, six payload bytes into a four-entry FIFO.
    data_ready = 1'b0;
    exp_start.push_back({8'hEC, 16'd10});
    send_byte(8'hEC); send_byte(8'h00); send_byte(8'h0A); send_byte(8'h00);
    for (int b = 1; b <= 6; b++) send_byte(8'(b));
    chk("ovf_flag", {31'b0, overflow}, 32'd1);
    chk("ovf_head", {24'b0, data}, 32'h01);
    for (int b = 1; b <= 4; b++) exp_data.push_back({1'b0, 8'(b)});
    data_ready = 1'b1;
    repeat (6) cyc();
    chk("ovf_empty", {31'b0, data_valid}, 32'd0);
    chk("ovf_sticky", {31'b0, overflow}, 32'd1);
    chk_drained("ovf");

    // Asynchronous reset mid-payload with bytes parked in the FIFO.
    data_ready = 1'b0;
    exp_start.push_back({8'hEC, 16'd8});
    send_byte(8'hEC); send_byte(8'h00); send_byte(8'h08); send_byte(8'h00);
    send_byte(8'hAA); send_byte(8'hBB);
    chk("pre_rst_valid", {31'b0, data_valid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk_zero("async_rst");
    @(posedge clk);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_drained("rst");
    apply_vec(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_alu_pkt_rx.md
Name: uart_alu_pkt_rx

Overview:
- Receive-side packet parser of the UART ALU: the responder end of the command byte stream the host/runner transmits.
- Consumes one-cycle byte strobes from the UART receiver and parses the 4-byte header {opcode, reserved, len_lsb, len_msb}.
- Validates opcode/length, then forwards payload bytes through a small ready/valid FIFO to the ALU/echo datapath.
- Reports framing errors and overflow; the UART RX cannot be back-pressured.

Parameters:
FIFO_DEPTH, 4, payload buffer entries (power of 2, >=2)
TIMEOUT_CYCLES, 100000, idle cycles between bytes mid-packet before abort (>=2)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
rx_data_i  in  8  byte from UART receiver
rx_valid_i  in  1  one-cycle strobe, rx_data_i valid
pkt_start_o  out  1  one-cycle pulse, header accepted
opcode_o  out  8  opcode of current packet, held until next pkt_start_o
len_o  out  16  total packet length incl. header, held like opcode_o
data_o  out  8  payload byte at FIFO head
data_last_o  out  1  data_o is final payload byte of packet
data_valid_o  out  1  FIFO non-empty
data_ready_i  in  1  consumer pops when data_valid_o && data_ready_i
err_o  out  1  one-cycle pulse, packet rejected/aborted
err_code_o  out  2  1 bad opcode, 2 bad length, 3 timeout; held until next err_o
overflow_o  out  1  sticky: payload byte dropped (FIFO full); cleared only by reset

Behaviour:
- Reset (async, any state): state IDLE; FIFO empty; all outputs 0; counters 0.
- Legal opcodes: ECHO 0xEC, ADD 0xAD, MUL 0x8A, DIV 0xD1.
- States: IDLE -> HDR_RSVD -> HDR_LLSB -> HDR_LMSB -> {PAYLOAD | DROP | IDLE}. Each transition is taken on a sampled rx_valid_i.
- IDLE: first byte is latched as opcode. Reserved byte is ignored (any value).
- Header check is done on the len_msb byte, L = {msb, lsb}:
  - L < 4 -> err code 2; back to IDLE.
  - Opcode illegal -> err code 1; DROP if L > 4, else IDLE.
  - ADD/MUL/DIV with (L-4) not a multiple of 4 or (L-4) < 8 -> err code 2; DROP.
  - Otherwise: pkt_start_o pulses the cycle after the len_msb strobe, and opcode_o/len_o update that same cycle. Next state is PAYLOAD if L > 4; ECHO with L == 4 returns to IDLE with no data.
- PAYLOAD: a 16-bit remaining counter is loaded with L-4 and decremented per byte.
  - Each byte is pushed as {last, byte}; last = (remaining == 1).
  - Pushed byte is visible on data_o/data_valid_o the next cycle (1-cycle latency when empty).
  - IDLE follows the last byte.
- DROP: counts and discards L-4 bytes, no pushes, then IDLE.
- FIFO full on push with no same-cycle pop: byte discarded, overflow_o set. The counter still decrements so framing stays aligned. If that byte was the last, no last marker is emitted.
- Push and pop in the same cycle while full: push accepted.
- Timeout: an idle counter runs in every non-IDLE state, is cleared on each rx_valid_i, and is held at 0 in IDLE.
  - Reaching TIMEOUT_CYCLES -> err_o pulse, code 3; IDLE.
  - FIFO contents are kept; the consumer discards the partial packet on err_o.
- err_o and pkt_start_o are never asserted together.
- err_o is registered: it pulses the cycle after the offending strobe or the timeout expiry.

Decomposition:
- Shared package: opcode constants (OP_ECHO, OP_ADD, OP_MUL, OP_DIV), header length constant HDR_BYTES=4, err_code enum, parser state enum.
- One sub-module: uart_alu_byte_fifo (parameterized depth, 9-bit entries, full/empty, simultaneous push/pop).

Test Plan:
- EC 00 06 00 69 42 (data_ready_i=1) -> pkt_start_o with opcode 0xEC, len 6; data 0x69 then 0x42 with data_last_o on 0x42; no err.
- 55 00 06 00 AA BB, then EC 00 04 00 -> err_o code 1, no data for the first packet; the second gives pkt_start_o with len 4 and no data.
- AD 00 07 00 01 02 03, then EC 00 05 00 77 -> err_o code 2, three bytes dropped; the next packet yields 0x77 with last.
- EC 00 08 00 11, then silence with TIMEOUT_CYCLES=50 -> err_o code 3 exactly 50 cycles after the 0x11 strobe; 0x11 is in the FIFO without last; the next header parses normally.
- data_ready_i=0, FIFO_DEPTH=4, packet EC 00 0A 00 01..06 -> FIFO holds 01..04, overflow_o=1; raise ready -> 01..04 drain, no last.
- Assert rst_i asynchronously mid-payload -> all outputs 0 immediately, FIFO empty; the next full packet parses correctly.
